// File: rtl/brq_lsu_pkg.sv
// Shared types and helpers for the brq load/store unit.
package brq_lsu_pkg;

   typedef enum logic {IDLE, WAIT} lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} lsu_size_e;

   // Access size lives in the low two func3 bits; bit 2 selects zero extension.
   function automatic lsu_size_e func3_size(input logic [2:0] f3);
      return lsu_size_e'(f3[1:0]);
   endfunction

   function automatic logic [7:0] size_mask(input lsu_size_e sz);
      case (sz)
         SZ_B:    return 8'h01;
         SZ_H:    return 8'h03;
         SZ_W:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/brq_lsu_align.sv
// Combinational alignment: misalignment check, byte enables, store replication,
// and load lane selection with sign/zero extension.
module brq_lsu_align
   import brq_lsu_pkg::*;
#(
   parameter int DataWidth = 32,
   localparam int Lanes = DataWidth / 8,
   localparam int OffW  = $clog2(DataWidth / 8)
) (
   input  logic [2:0]           req_func3,
   input  logic [OffW-1:0]      req_off,
   input  logic [DataWidth-1:0] store_data,
   output logic                 misaligned,
   output logic [Lanes-1:0]     be,
   output logic [DataWidth-1:0] wdata,
   input  logic [2:0]           rsp_func3,
   input  logic [OffW-1:0]      rsp_off,
   input  logic [DataWidth-1:0] rdata,
   output logic [DataWidth-1:0] load_data
);

   lsu_size_e            req_size;
   lsu_size_e            rsp_size;
   logic                 illegal;
   logic                 off_bad;
   int unsigned          rep;
   int unsigned          nbits;
   logic                 fill;
   logic [DataWidth-1:0] shifted;

   always_comb begin
      req_size = func3_size(req_func3);
      illegal  = (req_func3 == 3'b111) ||
                 ((DataWidth == 32) && ((req_func3 == F3_D) || (req_func3 == F3_WU)));
      case (req_size)
         SZ_H:    off_bad = req_off[0];
         SZ_W:    off_bad = |req_off[1:0];
         SZ_D:    off_bad = |req_off;
         default: off_bad = 1'b0;
      endcase
      misaligned = illegal | off_bad;

      be = Lanes'({8'h00, size_mask(req_size)} << req_off);

      // Each lane copies the byte at the same position within one access-size chunk.
      rep   = (32'd1 << req_size) - 32'd1;
      wdata = '0;
      for (int unsigned i = 0; i < Lanes; i++) begin
         wdata[8*i +: 8] = store_data[8*(i & rep) +: 8];
      end
   end

   always_comb begin
      rsp_size = func3_size(rsp_func3);
      shifted  = rdata >> {rsp_off, 3'b000};
      case (rsp_size)
         SZ_B:    begin nbits = 8;  fill = shifted[7];  end
         SZ_H:    begin nbits = 16; fill = shifted[15]; end
         SZ_W:    begin nbits = 32; fill = shifted[31]; end
         default: begin nbits = 64; fill = 1'b0;        end
      endcase
      fill      = fill & ~rsp_func3[2];
      load_data = shifted;
      for (int unsigned i = 0; i < DataWidth; i++) begin
         if (i >= nbits) load_data[i] = fill;
      end
   end

endmodule

// File: rtl/brq_lsu.sv
// brq_lsu: load/store stage with req/ack memory handshake, wait-state FSM and
// bus timeout; emits one registered writeback record per accepted instruction.
module brq_lsu
   import brq_lsu_pkg::*;
#(
   parameter int DataWidth     = 32,
   parameter int AddrWidth     = 15,
   parameter int RegAddrWidth  = 5,
   parameter int TimeoutCycles = 255
) (
   input  logic                    brq_clk,
   input  logic                    brq_rst,
   input  logic                    ieu_valid,
   input  logic                    ieu_load,
   input  logic                    ieu_store,
   input  logic [2:0]              ieu_func3,
   input  logic [DataWidth-1:0]    ieu_mem_addr,
   input  logic [DataWidth-1:0]    ieu_store_data,
   input  logic [DataWidth-1:0]    ieu_alu_result,
   input  logic [RegAddrWidth-1:0] ieu_addr_dst,
   input  logic                    ieu_regfile_en,
   input  logic                    ieu_memtoreg,
   output logic                    lsu_ready,
   output logic                    lsu_stall,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [AddrWidth-1:0]    mem_addr,
   output logic [DataWidth/8-1:0]  mem_be,
   output logic [DataWidth-1:0]    mem_wdata,
   input  logic                    mem_ack,
   input  logic [DataWidth-1:0]    mem_rdata,
   output logic                    ldst_valid,
   output logic [DataWidth-1:0]    ldst_load_data,
   output logic [DataWidth-1:0]    ldst_alu_result,
   output logic [RegAddrWidth-1:0] ldst_addr_dst,
   output logic                    ldst_regfile_en,
   output logic                    ldst_memtoreg,
   output logic                    lsu_misaligned,
   output logic                    lsu_timeout
);

   localparam int Lanes = DataWidth / 8;
   localparam int OffW  = $clog2(Lanes);
   localparam int CntW  = $clog2(TimeoutCycles + 1);

   lsu_state_e state, state_next;

   logic [CntW-1:0]         cnt;
   logic [2:0]              lat_func3;
   logic [OffW-1:0]         lat_off;
   logic [DataWidth-1:0]    lat_alu;
   logic [RegAddrWidth-1:0] lat_dst;
   logic                    lat_rfen;
   logic                    lat_m2r;

   logic                    align_mis;
   logic [Lanes-1:0]        align_be;
   logic [DataWidth-1:0]    align_wdata;
   logic [DataWidth-1:0]    align_load;

   logic do_pass, do_mis, do_mem, do_ack, do_to;
   logic unused_addr_hi;

   assign unused_addr_hi = ^ieu_mem_addr[DataWidth-1:OffW+AddrWidth];

   brq_lsu_align #(.DataWidth(DataWidth)) u_align (
      .req_func3  (ieu_func3),
      .req_off    (ieu_mem_addr[OffW-1:0]),
      .store_data (ieu_store_data),
      .misaligned (align_mis),
      .be         (align_be),
      .wdata      (align_wdata),
      .rsp_func3  (lat_func3),
      .rsp_off    (lat_off),
      .rdata      (mem_rdata),
      .load_data  (align_load)
   );

   assign lsu_ready = (state == IDLE);
   assign lsu_stall = ~lsu_ready;

   always_ff @(posedge brq_clk or posedge brq_rst) begin
      if (brq_rst) state <= IDLE;
      else         state <= state_next;
   end

   // Ack takes priority over the terminal count.
   always_comb begin
      do_pass    = 1'b0;
      do_mis     = 1'b0;
      do_mem     = 1'b0;
      do_ack     = 1'b0;
      do_to      = 1'b0;
      state_next = state;
      case (state)
         IDLE: begin
            if (ieu_valid) begin
               if (!(ieu_load || ieu_store))                  do_pass = 1'b1;
               else if ((ieu_load && ieu_store) || align_mis) do_mis  = 1'b1;
               else                                           do_mem  = 1'b1;
            end
            if (do_mem) state_next = WAIT;
         end
         WAIT: begin
            if (mem_ack)                                     do_ack = 1'b1;
            else if (cnt == CntW'(TimeoutCycles - 1))        do_to  = 1'b1;
            if (do_ack || do_to) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge brq_clk or posedge brq_rst) begin
      if (brq_rst) begin
         cnt       <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         lat_func3 <= '0;
         lat_off   <= '0;
         lat_alu   <= '0;
         lat_dst   <= '0;
         lat_rfen  <= 1'b0;
         lat_m2r   <= 1'b0;
      end else begin
         mem_req <= (state_next == WAIT);
         if (do_mem) begin
            cnt       <= '0;
            mem_we    <= ieu_store;
            mem_addr  <= ieu_mem_addr[OffW+AddrWidth-1:OffW];
            mem_be    <= align_be;
            mem_wdata <= align_wdata;
            lat_func3 <= ieu_func3;
            lat_off   <= ieu_mem_addr[OffW-1:0];
            lat_alu   <= ieu_alu_result;
            lat_dst   <= ieu_addr_dst;
            lat_rfen  <= ieu_regfile_en;
            lat_m2r   <= ieu_memtoreg;
         end else if (state == WAIT && !mem_ack) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge brq_clk or posedge brq_rst) begin
      if (brq_rst) begin
         ldst_valid      <= 1'b0;
         ldst_load_data  <= '0;
         ldst_alu_result <= '0;
         ldst_addr_dst   <= '0;
         ldst_regfile_en <= 1'b0;
         ldst_memtoreg   <= 1'b0;
         lsu_misaligned  <= 1'b0;
         lsu_timeout     <= 1'b0;
      end else begin
         ldst_valid     <= do_pass | do_mis | do_ack | do_to;
         lsu_misaligned <= do_mis;
         lsu_timeout    <= do_to;
         if (do_pass || do_mis) begin
            ldst_alu_result <= ieu_alu_result;
            ldst_addr_dst   <= ieu_addr_dst;
            ldst_regfile_en <= do_pass & ieu_regfile_en;
            ldst_memtoreg   <= ieu_memtoreg;
         end
         if (do_ack || do_to) begin
            ldst_alu_result <= lat_alu;
            ldst_addr_dst   <= lat_dst;
            ldst_regfile_en <= do_ack & lat_rfen;
            ldst_memtoreg   <= lat_m2r;
         end
         if (do_ack) ldst_load_data <= align_load;
      end
   end

endmodule
